// File: rtl/tug_match_controller_if.sv
// Press/row inputs and score/step outputs shared by the tug-of-war match controller.
// The master side drives requests and light position; the slave side is the controller.
interface tug_match_controller_if #(
  parameter int LIGHTS  = 9,
  parameter int SCORE_W = 3
);
  logic               new_game;
  logic               new_round;
  logic               p1_press;
  logic               p2_press;
  logic [LIGHTS:1]    light_pos;
  logic               step_p1;
  logic               step_p2;
  logic               row_reset;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               round_over;
  logic               game_over;
  logic [1:0]         winner;

  modport master (
    output new_game, new_round, p1_press, p2_press, light_pos,
    input  step_p1, step_p2, row_reset, p1_score, p2_score, round_over, game_over, winner
  );

  modport slave (
    input  new_game, new_round, p1_press, p2_press, light_pos,
    output step_p1, step_p2, row_reset, p1_score, p2_score, round_over, game_over, winner
  );
endinterface

// File: rtl/tug_match_controller.sv
// Match sequencer for the tug-of-war light row: filters presses into steps,
// scores rounds when the light hits an end, recentres between rounds, stops at WIN_SCORE.
module tug_match_controller #(
  parameter int LIGHTS      = 9,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 3,
  parameter int HOLD_CYCLES = 8
) (
  input logic                  clk,
  input logic                  reset,
  tug_match_controller_if.slave bus
);

  localparam int HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam bit AUTO_ADV = (HOLD_CYCLES != 0);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = AUTO_ADV ? HOLD_W'(HOLD_CYCLES - 1) : '0;
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {ROW_CLR, PLAY, ROUND_END, GAME_OVER} state_t;

  state_t              state, state_nxt;
  logic [SCORE_W-1:0]  p1_score_q, p2_score_q, p1_nxt, p2_nxt;
  logic [1:0]          winner_q, winner_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                step_p1_q, step_p2_q, row_reset_q;
  logic                step_p1_nxt, step_p2_nxt, row_reset_nxt;
  logic                round_over_q, game_over_q;
  logic                round_over_nxt, game_over_nxt;
  logic                p1_end, p2_end;

  // Scores saturate at WIN_SCORE so a stray win can never wrap the counter.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= WIN_VAL) ? WIN_VAL : s + 1'b1;
  endfunction

  assign p1_end = bus.light_pos[LIGHTS];
  assign p2_end = bus.light_pos[1];

  always_comb begin
    state_nxt     = state;
    p1_nxt        = p1_score_q;
    p2_nxt        = p2_score_q;
    winner_nxt    = winner_q;
    hold_nxt      = hold_cnt;
    step_p1_nxt   = 1'b0;
    step_p2_nxt   = 1'b0;
    row_reset_nxt = 1'b0;

    if (bus.new_game) begin
      state_nxt  = ROW_CLR;
      p1_nxt     = '0;
      p2_nxt     = '0;
      winner_nxt = 2'b00;
      hold_nxt   = '0;
    end else begin
      unique case (state)
        ROW_CLR: begin
          row_reset_nxt = 1'b1;
          state_nxt     = PLAY;
        end
        PLAY: begin
          if (p1_end && p2_end) begin
            // Both ends lit means the row is corrupt: recentre without scoring.
            state_nxt = ROW_CLR;
          end else if (p1_end) begin
            p1_nxt     = sat_inc(p1_score_q);
            winner_nxt = 2'b01;
            hold_nxt   = '0;
            state_nxt  = (p1_nxt == WIN_VAL) ? GAME_OVER : ROUND_END;
          end else if (p2_end) begin
            p2_nxt     = sat_inc(p2_score_q);
            winner_nxt = 2'b10;
            hold_nxt   = '0;
            state_nxt  = (p2_nxt == WIN_VAL) ? GAME_OVER : ROUND_END;
          end else begin
            step_p1_nxt = bus.p1_press & ~bus.p2_press;
            step_p2_nxt = bus.p2_press & ~bus.p1_press;
          end
        end
        ROUND_END: begin
          if (bus.new_round || (AUTO_ADV && hold_cnt == HOLD_LAST)) begin
            state_nxt = ROW_CLR;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        GAME_OVER: ;
        default: state_nxt = ROW_CLR;
      endcase
    end

    round_over_nxt = (state_nxt == ROUND_END) || (state_nxt == GAME_OVER);
    game_over_nxt  = (state_nxt == GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ROW_CLR;
      p1_score_q   <= '0;
      p2_score_q   <= '0;
      winner_q     <= 2'b00;
      hold_cnt     <= '0;
      step_p1_q    <= 1'b0;
      step_p2_q    <= 1'b0;
      row_reset_q  <= 1'b0;
      round_over_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state        <= state_nxt;
      p1_score_q   <= p1_nxt;
      p2_score_q   <= p2_nxt;
      winner_q     <= winner_nxt;
      hold_cnt     <= hold_nxt;
      step_p1_q    <= step_p1_nxt;
      step_p2_q    <= step_p2_nxt;
      row_reset_q  <= row_reset_nxt;
      round_over_q <= round_over_nxt;
      game_over_q  <= game_over_nxt;
    end
  end

  assign bus.step_p1    = step_p1_q;
  assign bus.step_p2    = step_p2_q;
  assign bus.row_reset  = row_reset_q;
  assign bus.p1_score   = p1_score_q;
  assign bus.p2_score   = p2_score_q;
  assign bus.winner     = winner_q;
  assign bus.round_over = round_over_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_tug_match_controller.sv
// Scoreboard bench for tug_match_controller: directed match scenarios plus random play,
// checked every cycle against a phase/countdown model of the match rules.
module tb_tug_match_controller;
  localparam int LIGHTS = 9;
  localparam int WIN    = 7;
  localparam int SW     = 3;
  localparam int HOLD   = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tug_match_controller_if #(.LIGHTS(LIGHTS), .SCORE_W(SW)) tif ();

  tug_match_controller #(
    .LIGHTS(LIGHTS), .WIN_SCORE(WIN), .SCORE_W(SW), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif.slave)
  );

  typedef struct packed {
    logic          sp1;
    logic          sp2;
    logic          rr;
    logic [SW-1:0] s1;
    logic [SW-1:0] s2;
    logic          ro;
    logic          go;
    logic [1:0]    w;
  } obs_t;

  obs_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle_no = 0;

  // Reference model: match phase plus a countdown of remaining hold cycles.
  localparam int PH_CLEAR = 0, PH_PLAY = 1, PH_HOLD = 2, PH_DONE = 3;
  int m_ph, m_s1, m_s2, m_w, m_left;

  localparam logic [LIGHTS:1] MID  = 9'b0_0001_0000;
  localparam logic [LIGHTS:1] END1 = 9'b0_0000_0001;
  localparam logic [LIGHTS:1] ENDN = 9'b1_0000_0000;

  task automatic cyc(input bit rst, input bit ng, input bit nr, input bit a, input bit b,
                     input logic [LIGHTS:1] lp);
    obs_t e;
    @(negedge clk);
    reset = rst; tif.new_game = ng; tif.new_round = nr;
    tif.p1_press = a; tif.p2_press = b; tif.light_pos = lp;
    e = '0;
    if (rst) begin
      m_ph = PH_CLEAR; m_s1 = 0; m_s2 = 0; m_w = 0; m_left = 0;
    end else if (ng) begin
      m_ph = PH_CLEAR; m_s1 = 0; m_s2 = 0; m_w = 0;
    end else begin
      case (m_ph)
        PH_CLEAR: begin e.rr = 1'b1; m_ph = PH_PLAY; end
        PH_PLAY: begin
          if (lp[LIGHTS] && lp[1]) m_ph = PH_CLEAR;
          else if (lp[LIGHTS]) begin
            m_s1++; m_w = 1; m_left = HOLD;
            m_ph = (m_s1 == WIN) ? PH_DONE : PH_HOLD;
          end else if (lp[1]) begin
            m_s2++; m_w = 2; m_left = HOLD;
            m_ph = (m_s2 == WIN) ? PH_DONE : PH_HOLD;
          end else begin
            e.sp1 = a && !b;
            e.sp2 = b && !a;
          end
        end
        PH_HOLD: begin
          m_left--;
          if (nr || (HOLD != 0 && m_left == 0)) m_ph = PH_CLEAR;
        end
        default: ;
      endcase
    end
    e.s1 = SW'(m_s1);
    e.s2 = SW'(m_s2);
    e.w  = 2'(m_w);
    e.ro = (m_ph == PH_HOLD) || (m_ph == PH_DONE);
    e.go = (m_ph == PH_DONE);
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, MID);
  endtask

  // Monitor: every cycle after the edge, compare the DUT outputs with the oldest expectation.
  initial begin
    obs_t e, g;
    forever begin
      @(posedge clk);
      #2;
      cycle_no++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        g = '{sp1: tif.step_p1, sp2: tif.step_p2, rr: tif.row_reset, s1: tif.p1_score,
              s2: tif.p2_score, ro: tif.round_over, go: tif.game_over, w: tif.winner};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got sp1=%b sp2=%b rr=%b s1=%0d s2=%0d ro=%b go=%b w=%b, expected sp1=%b sp2=%b rr=%b s1=%0d s2=%0d ro=%b go=%b w=%b",
                   cycle_no, g.sp1, g.sp2, g.rr, g.s1, g.s2, g.ro, g.go, g.w,
                   e.sp1, e.sp2, e.rr, e.s1, e.s2, e.ro, e.go, e.w);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LIGHTS:1] lp;
    int r;
    reset = 1'b1; tif.new_game = 0; tif.new_round = 0;
    tif.p1_press = 0; tif.p2_press = 0; tif.light_pos = '0;

    cyc(1, 0, 0, 0, 0, MID);
    cyc(1, 0, 0, 0, 0, MID);
    idle(2);
    cyc(0, 0, 0, 1, 0, MID); idle(1);
    cyc(0, 0, 0, 1, 1, MID); idle(1);
    cyc(0, 0, 0, 0, 1, '0);  idle(1);

    // P1 wins, auto-advance after the hold period.
    cyc(0, 0, 0, 0, 0, ENDN);
    idle(12);

    // P1 wins again, presses ignored while held, early new_round at hold count 2.
    cyc(0, 0, 0, 0, 0, ENDN);
    cyc(0, 0, 0, 1, 0, MID);
    cyc(0, 0, 0, 0, 1, MID);
    cyc(0, 0, 1, 1, 1, ENDN);
    idle(2);
    cyc(0, 0, 0, 0, 0, ENDN | END1);
    idle(2);

    // P2 takes seven rounds and the match.
    for (int i = 0; i < WIN; i++) begin
      cyc(0, 0, 0, 0, 0, END1);
      cyc(0, 0, 1, 0, 0, MID);
      idle(1);
    end
    cyc(0, 0, 0, 0, 0, END1);
    cyc(0, 0, 1, 1, 0, ENDN);
    cyc(0, 0, 0, 0, 1, MID);
    cyc(0, 1, 0, 0, 0, MID);
    idle(2);
    cyc(0, 0, 0, 1, 0, MID);
    cyc(1, 0, 0, 1, 0, MID);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 15);
      case (r)
        0: lp = ENDN;
        1: lp = END1;
        2: lp = ENDN | END1;
        3: lp = '0;
        default: lp = MID >> 4 << $urandom_range(1, 7);
      endcase
      cyc(($urandom % 300) == 0, ($urandom % 150) == 0, ($urandom % 20) == 0,
          ($urandom % 3) == 0, ($urandom % 3) == 0, lp);
    end

    @(posedge clk);
    #3;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
